// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel, decode-side
// valid/ready channel with branch redirect inputs, and status outputs.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] ImmExt;
    logic        trap_misaligned;
    logic [31:0] retired_count;

    modport master (
        output imem_req, imem_addr, instruction, instr_pc, instr_valid,
               trap_misaligned, retired_count,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, ImmExt
    );

    modport slave (
        input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
               trap_misaligned, retired_count,
        output imem_ack, imem_rdata, instr_ready, branch_taken, ImmExt
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a variable-latency req/ack
// memory channel, hands instructions to decode and redirects on taken branches.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ret_q, ret_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        trap_q, trap_d;
    logic [31:0] target_s;
    logic        misaligned_s;

    function automatic logic [31:0] next_target(input logic [31:0] base,
                                                input logic        taken,
                                                input logic [31:0] imm);
        if (taken) begin
            return base + imm;
        end else begin
            return base + 32'd4;
        end
    endfunction

    // Redirect target and alignment status for the held instruction
    always_comb begin
        target_s     = next_target(ipc_q, bus.branch_taken, bus.ImmExt);
        misaligned_s = 1'b0;
        if (ALIGN_CHECK) begin
            misaligned_s = (target_s[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ret_d   = ret_q;
        req_d   = req_q;
        valid_d = valid_q;
        trap_d  = trap_q;
        case (state_q)
            FETCH: begin
                // req is low only in the first cycle out of reset; acks are ignored then
                if (req_q) begin
                    if (bus.imem_ack) begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    ret_d   = ret_q + 32'd1;
                    valid_d = 1'b0;
                    if (misaligned_s) begin
                        trap_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = {target_s[31:2], 2'b00};
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                trap_d  = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                state_d = FETCH;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            ret_q   <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ret_q   <= ret_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            trap_q  <= trap_d;
        end
    end

    assign bus.imem_req        = req_q;
    assign bus.imem_addr       = pc_q;
    assign bus.instruction     = instr_q;
    assign bus.instr_pc        = ipc_q;
    assign bus.instr_valid     = valid_q;
    assign bus.trap_misaligned = trap_q;
    assign bus.retired_count   = ret_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the immediate generator: owns the program counter and fetches instructions from an instruction memory with variable latency over a req/ack handshake.
- Presents each instruction and its PC to the decode side (opcode split, immediate generation) with a valid/ready handshake.
- Computes the next PC from the decode side's branch decision and sign-extended immediate (ImmExt): PC+4 or PC+ImmExt.
- Traps and halts on a misaligned branch target.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- ALIGN_CHECK, 1, when 1 a branch target with bits [1:0] != 0 traps; when 0 bits [1:0] are forced to 0 and no trap is raised.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory has returned data; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; valid in the cycle imem_ack=1.
- instruction  out  32  held instruction for decode.
- instr_pc  out  32  address of the held instruction.
- instr_valid  out  1  instruction/instr_pc are valid.
- instr_ready  in  1  decode consumes the instruction this cycle.
- branch_taken  in  1  redirect to instr_pc+ImmExt; sampled only on consume.
- ImmExt  in  32  sign-extended branch offset, two's complement.
- trap_misaligned  out  1  sticky; misaligned target detected, fetch halted.
- retired_count  out  32  number of consumed instructions; wraps modulo 2^32.

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-fetch):
- pc=RESET_PC; imem_req=0; instruction=0; instr_pc=0; instr_valid=0; trap_misaligned=0; retired_count=0; state=FETCH.
- An imem_ack arriving in the reset cycle or the cycle after reset is ignored unless imem_req=1.

States: FETCH, HOLD, HALT. All outputs are registered. imem_addr is driven combinationally from the pc register.

FETCH:
- imem_req=1 and imem_addr=pc. imem_req and imem_addr stay stable until the ack.
- On a rising edge with imem_ack=1:
  - instruction<=imem_rdata; instr_pc<=pc; instr_valid<=1; imem_req<=0; state<=HOLD.
- Memory latency is unbounded. Minimum latency: an ack in the first FETCH cycle gives instr_valid=1 on the next cycle.

HOLD:
- instr_valid=1 and imem_req=0. instruction and instr_pc stay stable while instr_ready=0.
- On a rising edge with instr_ready=1 (consume):
  - retired_count<=retired_count+1.
  - target = branch_taken ? instr_pc+ImmExt : instr_pc+32'd4. The add is 32-bit with carry discarded (wrap: 0xFFFF_FFFC+4 -> 0; 0x0+0xFFFF_FFF8 -> 0xFFFF_FFF8).
  - If ALIGN_CHECK=1 and target[1:0]!=0: trap_misaligned<=1; instr_valid<=0; pc unchanged; state<=HALT.
  - Otherwise: pc<=target (target[1:0] cleared when ALIGN_CHECK=0); instr_valid<=0; state<=FETCH.
- branch_taken and ImmExt are ignored when no consume occurs.
- Sustained throughput is one instruction per 2 cycles (FETCH+HOLD) with zero-latency memory.

HALT:
- imem_req=0; instr_valid=0; trap_misaligned=1. Only reset exits HALT.
- imem_ack, instr_ready and branch_taken are ignored.

Simultaneous events:
- instr_ready while instr_valid=0 has no effect.
- imem_ack while imem_req=0 has no effect.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, memory acks immediately with 0x00000013, instr_ready=1, branch_taken=0 -> imem_addr sequence 0x0,0x4,0x8; instr_valid high every other cycle; retired_count=3 after 3 consumes.
- Variable latency: ack delayed 5 cycles -> imem_req held high for 6 cycles with imem_addr=0x4 constant; instr_valid stays 0 until the cycle after the ack.
- Backpressure: instr_ready=0 for 4 cycles with instruction=0x00A00093 -> instruction and instr_pc unchanged, no new imem_req, retired_count unchanged.
- Branch: instr_pc=0x100, branch_taken=1, ImmExt=0xFFFFFFF8 -> next imem_addr=0xF8. Wrap case: instr_pc=0xFFFFFFFC, not taken -> next imem_addr=0x0.
- Misaligned: ALIGN_CHECK=1, instr_pc=0x20, ImmExt=0x6, taken -> trap_misaligned=1, imem_req stays 0 for 10 cycles. With ALIGN_CHECK=0 the same stimulus -> imem_addr=0x24.
- Reset mid-fetch: assert reset while imem_req=1 awaiting ack -> imem_req=0 immediately (asynchronous). After release, first imem_addr=RESET_PC and retired_count=0.
